// File: rtl/motoro3_step_seq.sv
// motoro3_step_seq: six-step commutation sequencer for the 3-phase motor path.
// Turns the step period, sub-step split and enable settings into step/sub-step
// indices, tick pulses and one-hot high/low phase selects for the PWM stage.
// Optional soft-start ramp: define M3_SOFT_START_EN to compile it in.
module motoro3_step_seq #(
    parameter logic [24:0] MIN_PERIOD   = 25'd32,
    parameter logic [23:0] ALIGN_CLKS   = 24'd1_000_000,
    parameter logic [24:0] START_PERIOD = 25'd1_666_667,
    parameter logic [24:0] RAMP_DEC     = 25'd16_667
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] m3r_stepCNT_speedSET,
    input  logic [1:0]  m3r_stepSplitMax,
    input  logic        m3_enable,
    input  logic        m3_dir,
    output logic [2:0]  m3s_stepIdx,
    output logic [2:0]  m3s_subIdx,
    output logic        m3s_stepTick,
    output logic        m3s_subTick,
    output logic [2:0]  m3s_hiSel,
    output logic [2:0]  m3s_loSel,
    output logic        m3s_running
);

    typedef enum logic [1:0] {StIdle, StAlign, StRun} state_t;

    state_t      state;
    logic [23:0] align_cnt;
    logic [24:0] sub_cnt;
    logic [24:0] peff;
    logic [1:0]  split_l;
    logic        dir_l;

    logic [24:0] p_in;
    logic [24:0] peff_entry;
    logic [24:0] peff_step;
    logic        dir_step;
    logic [2:0]  step_adv;
    logic [2:0]  sub_last;
    logic [3:0]  sub_cnt_max;

    // High-side select for a step: A,A,B,B,C,C
    function automatic logic [2:0] hi_dec(input logic [2:0] s);
        case (s)
            3'd0, 3'd1: hi_dec = 3'b001;
            3'd2, 3'd3: hi_dec = 3'b010;
            3'd4, 3'd5: hi_dec = 3'b100;
            default:    hi_dec = 3'b000;
        endcase
    endfunction

    // Low-side select for a step: B,C,C,A,A,B
    function automatic logic [2:0] lo_dec(input logic [2:0] s);
        case (s)
            3'd0, 3'd5: lo_dec = 3'b010;
            3'd1, 3'd2: lo_dec = 3'b100;
            3'd3, 3'd4: lo_dec = 3'b001;
            default:    lo_dec = 3'b000;
        endcase
    endfunction

    // Clamped target period, next effective period, next direction and step index
    always_comb begin
        p_in        = (m3r_stepCNT_speedSET < MIN_PERIOD) ? MIN_PERIOD : m3r_stepCNT_speedSET;
        sub_cnt_max = (4'd1 << split_l) - 4'd1;
        sub_last    = sub_cnt_max[2:0];
`ifdef M3_SOFT_START_EN
        peff_entry = START_PERIOD;
        // Compare the gap before subtracting so the ramp can never underflow
        if ((peff > p_in) && ((peff - p_in) > RAMP_DEC)) begin
            peff_step = peff - RAMP_DEC;
        end else begin
            peff_step = p_in;
        end
        // Direction is frozen while the ramp is still above target
        dir_step = (peff_step > p_in) ? dir_l : m3_dir;
`else
        peff_entry = p_in;
        peff_step  = p_in;
        dir_step   = m3_dir;
`endif
        if (dir_l) begin
            step_adv = (m3s_stepIdx == 3'd0) ? 3'd5 : m3s_stepIdx - 3'd1;
        end else begin
            step_adv = (m3s_stepIdx == 3'd5) ? 3'd0 : m3s_stepIdx + 3'd1;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            align_cnt    <= '0;
            sub_cnt      <= '0;
            peff         <= '0;
            split_l      <= '0;
            dir_l        <= 1'b0;
            m3s_stepIdx  <= '0;
            m3s_subIdx   <= '0;
            m3s_stepTick <= 1'b0;
            m3s_subTick  <= 1'b0;
            m3s_hiSel    <= '0;
            m3s_loSel    <= '0;
            m3s_running  <= 1'b0;
        end else begin
            m3s_stepTick <= 1'b0;
            m3s_subTick  <= 1'b0;
            if (!m3_enable) begin
                state       <= StIdle;
                align_cnt   <= '0;
                sub_cnt     <= '0;
                peff        <= '0;
                split_l     <= '0;
                dir_l       <= 1'b0;
                m3s_stepIdx <= '0;
                m3s_subIdx  <= '0;
                m3s_hiSel   <= '0;
                m3s_loSel   <= '0;
                m3s_running <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        state       <= StAlign;
                        align_cnt   <= ALIGN_CLKS - 24'd1;
                        m3s_stepIdx <= 3'd0;
                        m3s_subIdx  <= 3'd0;
                        m3s_hiSel   <= hi_dec(3'd0);
                        m3s_loSel   <= lo_dec(3'd0);
                    end
                    StAlign: begin
                        if (align_cnt == 24'd0) begin
                            state       <= StRun;
                            m3s_running <= 1'b1;
                            peff        <= peff_entry;
                            split_l     <= m3r_stepSplitMax;
                            dir_l       <= m3_dir;
                            sub_cnt     <= (peff_entry >> m3r_stepSplitMax) - 25'd1;
                        end else begin
                            align_cnt <= align_cnt - 24'd1;
                        end
                    end
                    StRun: begin
                        if (sub_cnt == 25'd0) begin
                            m3s_subTick <= 1'b1;
                            if (m3s_subIdx == sub_last) begin
                                // Step boundary: advance and relatch the settings
                                m3s_stepTick <= 1'b1;
                                m3s_subIdx   <= 3'd0;
                                m3s_stepIdx  <= step_adv;
                                m3s_hiSel    <= hi_dec(step_adv);
                                m3s_loSel    <= lo_dec(step_adv);
                                peff         <= peff_step;
                                split_l      <= m3r_stepSplitMax;
                                dir_l        <= dir_step;
                                sub_cnt      <= (peff_step >> m3r_stepSplitMax) - 25'd1;
                            end else begin
                                m3s_subIdx <= m3s_subIdx + 3'd1;
                                sub_cnt    <= (peff >> split_l) - 25'd1;
                            end
                        end else begin
                            sub_cnt <= sub_cnt - 25'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motoro3_step_seq.sv
// Directed bench for motoro3_step_seq with a shortened align hold (10 clks).
module tb_motoro3_step_seq;

    logic        clk;
    logic        rst;
    logic [24:0] speed;
    logic [1:0]  split;
    logic        enable;
    logic        dir;
    logic [2:0]  step_idx;
    logic [2:0]  sub_idx;
    logic        step_tick;
    logic        sub_tick;
    logic [2:0]  hi_sel;
    logic [2:0]  lo_sel;
    logic        running;
    logic [14:0] all_outs;

    int passed = 0;
    int total  = 0;
    int n;
    logic [2:0] exp_hi [0:5];
    logic [2:0] exp_lo [0:5];

    assign all_outs = {step_idx, sub_idx, step_tick, sub_tick, hi_sel, lo_sel, running};

    motoro3_step_seq #(
        .ALIGN_CLKS(24'd10)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .m3r_stepCNT_speedSET (speed),
        .m3r_stepSplitMax     (split),
        .m3_enable            (enable),
        .m3_dir               (dir),
        .m3s_stepIdx          (step_idx),
        .m3s_subIdx           (sub_idx),
        .m3s_stepTick         (step_tick),
        .m3s_subTick          (sub_tick),
        .m3s_hiSel            (hi_sel),
        .m3s_loSel            (lo_sel),
        .m3s_running          (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Cycles until the next stepTick, sampled 1 ns after each edge
    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (step_tick !== 1'b1 && cnt < 2000);
    endtask

    task automatic wait_sub(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (sub_tick !== 1'b1 && cnt < 2000);
    endtask

    initial begin
        exp_hi = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        exp_lo = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
        rst    = 1'b1;
        enable = 1'b0;
        speed  = 25'd100;
        split  = 2'd0;
        dir    = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(all_outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_outs", 32'(all_outs), 32'd0);

        // Align: step-0 selects for exactly 10 clks, then RUN with no stepTick
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("align_hi", 32'(hi_sel), 32'b001);
        check("align_lo", 32'(lo_sel), 32'b010);
        check("align_running", 32'(running), 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check("align_last_cycle", 32'(running), 32'd0);
        @(posedge clk);
        #1;
        check("run_entry_running", 32'(running), 32'd1);
        check("run_entry_step", 32'(step_idx), 32'd0);
        check("run_entry_notick", 32'(step_tick), 32'd0);

        // Forward run, split 0, period 100: 1,2,3,4,5,0
        for (int i = 0; i < 6; i++) begin
            wait_step(n);
            check("fwd_period", 32'(n), 32'd100);
            check("fwd_step", 32'(step_idx), 32'((i + 1) % 6));
            check("fwd_hi", 32'(hi_sel), 32'(exp_hi[(i + 1) % 6]));
            check("fwd_lo", 32'(lo_sel), 32'(exp_lo[(i + 1) % 6]));
            check("fwd_subtick", 32'(sub_tick), 32'd1);
        end

        // Split=2 takes effect at the next step boundary
        split = 2'd2;
        wait_step(n);
        check("split_latch_period", 32'(n), 32'd100);
        check("split_latch_step", 32'(step_idx), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            wait_sub(n);
            check("sub_period", 32'(n), 32'd25);
            check("sub_idx", 32'(sub_idx), 32'(j % 4));
            check("sub_steptick", 32'(step_tick), 32'(j == 4));
        end
        check("split_step", 32'(step_idx), 32'd2);

        // 103 >> 2 = 25, so steps stay 100 clks
        speed = 25'd103;
        wait_step(n);
        check("p103_prev_period", 32'(n), 32'd100);
        wait_step(n);
        check("p103_period", 32'(n), 32'd100);
        check("p103_step", 32'(step_idx), 32'd4);

        // Back to split 0 / 100; stepTick is a single-cycle pulse
        speed = 25'd100;
        split = 2'd0;
        @(posedge clk);
        #1;
        check("steptick_pulse", 32'(step_tick), 32'd0);
        check("subtick_pulse", 32'(sub_tick), 32'd0);
        wait_step(n);
        check("restore_period", 32'(n), 32'd99);
        check("restore_step", 32'(step_idx), 32'd5);

        // Mid-step change at 40 clks: current step still ends at 100
        repeat (40) @(posedge clk);
        #1;
        speed = 25'd200;
        wait_step(n);
        check("midchg_rest", 32'(n), 32'd60);
        check("midchg_wrap", 32'(step_idx), 32'd0);
        wait_step(n);
        check("midchg_next", 32'(n), 32'd200);
        check("midchg_step", 32'(step_idx), 32'd1);

        // Disable clears everything on the next edge
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable_outs", 32'(all_outs), 32'd0);

        // Clamp to 32 and reverse direction: 0,5,4,3
        speed  = 25'd5;
        dir    = 1'b1;
        enable = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("rev_running", 32'(running), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_step(n);
            check("rev_period", 32'(n), 32'd32);
            check("rev_step", 32'(step_idx), 32'(5 - k));
        end

        // Asynchronous reset mid-RUN at step 3
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", 32'(all_outs), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("realign_hi", 32'(hi_sel), 32'b001);
        check("realign_running", 32'(running), 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check("realign_last_cycle", 32'(running), 32'd0);
        @(posedge clk);
        #1;
        check("realign_run", 32'(running), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
